imem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 128-bit-line instruction/line memory (256 x 128).
- Requester 0 is the I-cache refill port and requester 1 is the D-cache/prefetch refill port.
- Serialises line-fill requests onto the single memory port and returns the line to the winner with a one-cycle done pulse.
- Adds a bounded-wait timeout so a missing memory handshake cannot hang a cache.

---
 rtl/imem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Round-robin arbiter that serialises two cache line-fill requesters onto one
// line-memory port, with a bounded wait on the memory handshake.
module imem_arbiter #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_done,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_done,
    output logic              r1_err,
    output logic [LINE_W-1:0] rsp_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_data_in,
    input  logic              mem_done_in,
    output logic              grant_id,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q,    state_d;
    logic              grant_q,    grant_d;
    logic              last_q,     last_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LINE_W-1:0] rsp_q,      rsp_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              r0_done_q,  r0_done_d;
    logic              r1_done_q,  r1_done_d;
    logic              r0_err_q,   r0_err_d;
    logic              r1_err_q,   r1_err_d;
    logic              mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q,     busy_d;

    logic win_c;
    logic finish_c;
    logic tmo_c;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the memory port and done pulses come straight from flops.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        rsp_d      = rsp_q;
        cnt_d      = cnt_q;
        r0_done_d  = 1'b0;
        r1_done_d  = 1'b0;
        r0_err_d   = 1'b0;
        r1_err_d   = 1'b0;
        mem_req_d  = 1'b0;
        mem_addr_d = '0;
        finish_c   = 1'b0;
        tmo_c      = 1'b0;
        win_c      = (r0_req & r1_req) ? ~last_q : r1_req;

        case (state_q)
            S_IDLE: begin
                if (r0_req | r1_req) begin
                    grant_d    = win_c;
                    last_d     = win_c;
                    addr_d     = win_c ? r1_addr : r0_addr;
                    cnt_d      = '0;
                    state_d    = S_ACCESS;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_d;
                end
            end
            S_ACCESS: begin
                // A memory handshake on the last allowed cycle beats the timeout.
                if (mem_done_in) begin
                    rsp_d    = mem_data_in;
                    finish_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_d    = '0;
                    tmo_c    = 1'b1;
                    finish_c = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                end
                if (finish_c) begin
                    state_d   = S_RESP;
                    r0_done_d = ~grant_q;
                    r1_done_d = grant_q;
                    r0_err_d  = ~grant_q & tmo_c;
                    r1_err_d  = grant_q & tmo_c;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            rsp_q      <= '0;
            cnt_q      <= '0;
            r0_done_q  <= 1'b0;
            r1_done_q  <= 1'b0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            rsp_q      <= rsp_d;
            cnt_q      <= cnt_d;
            r0_done_q  <= r0_done_d;
            r1_done_q  <= r1_done_d;
            r0_err_q   <= r0_err_d;
            r1_err_q   <= r1_err_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign r0_done  = r0_done_q;
    assign r1_done  = r1_done_q;
    assign r0_err   = r0_err_q;
    assign r1_err   = r1_err_q;
    assign rsp_data = rsp_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_imem_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned LW  = 128;
    localparam int          TMO = 16;

    localparam logic [LW-1:0] LIT05 = {4{32'h0000_0005}};
    localparam logic [LW-1:0] LIT10 = 128'h1010_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [LW-1:0] LIT20 = 128'h2020_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
    localparam logic [LW-1:0] LIT33 = 128'h3333_0123_4567_89AB_CDEF_FEDC_BA98_7654;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          r0_req  = 1'b0;
    logic          r1_req  = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [AW-1:0] r1_addr = '0;
    logic          r0_done, r0_err, r1_done, r1_err;
    logic [LW-1:0] rsp_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_data_in;
    logic          mem_done_in = 1'b0;
    logic          grant_id;
    logic          busy;

    logic [LW-1:0] mem_arr [256];
    assign mem_data_in = mem_arr[mem_addr];

    imem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_done(r1_done), .r1_err(r1_err),
        .rsp_data(rsp_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_done_in(mem_done_in),
        .grant_id(grant_id), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Memory environment knobs: fixed latency (>=0) or random (-1), noise on idle handshake.
    int force_lat = 0;
    bit noise_en  = 1'b0;
    int acc       = 0;
    int lat       = 0;

    // Reference model: one outstanding transfer, described by who owns memory and who is answered.
    bit            model_on = 1'b0;
    int            m_acc    = -1;
    int            m_resp   = -1;
    int            m_last   = 1;
    int            m_wait   = 0;
    logic [AW-1:0] m_addr   = '0;
    logic [LW-1:0] m_data   = '0;
    logic          m_err    = 1'b0;
    int            w;
    bit            md;
    bit            e_busy;

    // Observations for the directed scenarios.
    int            cyc = 0;
    int            memreq_cnt = 0;
    int            done_who[$];
    int            done_cyc[$];
    logic          done_err[$];
    logic [LW-1:0] done_data[$];

    always @(negedge clk) begin
        cyc++;
        if (model_on) begin
            e_busy = (m_acc >= 0) || (m_resp >= 0);
            chk1("busy", busy, e_busy);
            chk1("mem_req", mem_req, m_acc >= 0);
            chkv("mem_addr", LW'(mem_addr), (m_acc >= 0) ? LW'(m_addr) : '0);
            chk1("r0_done", r0_done, m_resp == 0);
            chk1("r1_done", r1_done, m_resp == 1);
            chk1("r0_err", r0_err, (m_resp == 0) && m_err);
            chk1("r1_err", r1_err, (m_resp == 1) && m_err);
            if (e_busy) chk1("grant_id", grant_id, (m_acc >= 0) ? (m_acc == 1) : (m_resp == 1));
            if (m_resp >= 0) chkv("rsp_data", rsp_data, m_data);
        end
        if (mem_req === 1'b1) memreq_cnt++;
        if (r0_done === 1'b1) begin
            done_who.push_back(0); done_cyc.push_back(cyc);
            done_err.push_back(r0_err); done_data.push_back(rsp_data);
        end
        if (r1_done === 1'b1) begin
            done_who.push_back(1); done_cyc.push_back(cyc);
            done_err.push_back(r1_err); done_data.push_back(rsp_data);
        end

        // Memory responder reacting to the port it actually sees.
        if (mem_req === 1'b1) begin
            acc++;
            if (acc == 1) begin
                if (force_lat >= 0) lat = force_lat;
                else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: lat = 0;
                        5, 6, 7:       lat = $urandom_range(1, 5);
                        8:             lat = TMO - 1;
                        default:       lat = 1000;
                    endcase
                end
            end
            md = (acc > lat);
        end else begin
            acc = 0;
            md  = noise_en && ($urandom_range(0, 1) == 1);
        end
        mem_done_in = md;

        // Advance the model by the upcoming clock edge.
        if (reset_n === 1'b0) begin
            model_on = 1'b1;
            m_acc    = -1;
            m_resp   = -1;
            m_last   = 1;
        end else if (model_on) begin
            if (m_resp >= 0) begin
                m_resp = -1;
            end else if (m_acc >= 0) begin
                m_wait++;
                if (md) begin
                    m_data = mem_arr[m_addr]; m_err = 1'b0; m_resp = m_acc; m_acc = -1;
                end else if (m_wait == TMO) begin
                    m_data = '0; m_err = 1'b1; m_resp = m_acc; m_acc = -1;
                end
            end else begin
                if (r0_req && r1_req) w = 1 - m_last;
                else if (r0_req)      w = 0;
                else if (r1_req)      w = 1;
                else                  w = -1;
                if (w >= 0) begin
                    m_acc  = w;
                    m_last = w;
                    m_addr = (w == 1) ? r1_addr : r0_addr;
                    m_wait = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        done_who.delete(); done_cyc.delete(); done_err.delete(); done_data.delete();
        memreq_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        r0_req  = 1'b0;
        r1_req  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        clear_obs();
    endtask

    // Drive requesters until n done pulses are seen; keep=1 re-requests back-to-back.
    task automatic serve(input int n, input bit keep, input int budget);
        logic d0, d1;
        int   left;
        left = budget;
        while (done_who.size() < n && left > 0) begin
            @(negedge clk);
            d0 = r0_done;
            d1 = r1_done;
            tick();
            if (d0) begin
                if (keep && done_who.size() < n) r0_addr = AW'($urandom_range(0, 255));
                else r0_req = 1'b0;
            end
            if (d1) begin
                if (keep && done_who.size() < n) r1_addr = AW'($urandom_range(0, 255));
                else r1_req = 1'b0;
            end
            left--;
        end
        if (done_who.size() < n) begin
            checks++;
            failures++;
            $display("FAIL serve_timeout: got %0d dones want %0d", done_who.size(), n);
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    initial begin
        int c0, k, left;
        logic d0, d1;

        foreach (mem_arr[i]) mem_arr[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_arr[8'h05] = LIT05;
        mem_arr[8'h10] = LIT10;
        mem_arr[8'h20] = LIT20;
        mem_arr[8'h33] = LIT33;

        // Reset values.
        do_reset();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chkv("rst_mem_addr", LW'(mem_addr), '0);
        chkv("rst_rsp_data", rsp_data, '0);
        chk1("rst_grant", grant_id, 1'b0);
        chk1("rst_done", r0_done | r1_done, 1'b0);
        tick();

        // Single request against combinational memory.
        force_lat = 0;
        r0_req  = 1'b1;
        r0_addr = 8'h05;
        c0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk1("single_mem_req", mem_req, 1'b1);
        chkv("single_mem_addr", LW'(mem_addr), LW'(8'h05));
        @(negedge clk);
        chk1("single_r0_done", r0_done, 1'b1);
        chkv("single_rsp", rsp_data, 128'h00000005_00000005_00000005_00000005);
        chk1("single_r0_err", r0_err, 1'b0);
        chk1("single_r1_done", r1_done, 1'b0);
        tick();
        r0_req = 1'b0;
        chki("single_latency", done_cyc[0] - c0, 3);
        chki("single_mem_cycles", memreq_cnt, 1);

        // Simultaneous requests right after reset: r0 first, then r1.
        do_reset();
        r0_req = 1'b1; r0_addr = 8'h10;
        r1_req = 1'b1; r1_addr = 8'h20;
        serve(2, 1'b0, 30);
        if (done_who.size() >= 2) begin
            chki("tie_first", done_who[0], 0);
            chki("tie_second", done_who[1], 1);
            chki("tie_gap", done_cyc[1] - done_cyc[0], 3);
            chkv("tie_data0", done_data[0], LIT10);
            chkv("tie_data1", done_data[1], LIT20);
        end

        // Fairness under continuous contention.
        do_reset();
        r0_req = 1'b1; r0_addr = AW'($urandom_range(0, 255));
        r1_req = 1'b1; r1_addr = AW'($urandom_range(0, 255));
        serve(6, 1'b1, 60);
        for (int i = 0; i < 6 && i < done_who.size(); i++) begin
            chki("fair_order", done_who[i], i % 2);
            if (i > 0) chki("fair_gap", done_cyc[i] - done_cyc[i-1], 3);
        end
        tick(); tick();

        // Slow memory, requester address disturbed mid-access.
        clear_obs();
        force_lat = 4;
        r1_req = 1'b1; r1_addr = 8'h33;
        tick(); tick();
        r1_addr = 8'h77;
        serve(1, 1'b0, 30);
        if (done_who.size() >= 1) begin
            chki("slow_who", done_who[0], 1);
            chkv("slow_data", done_data[0], LIT33);
            chk1("slow_err", done_err[0], 1'b0);
        end
        chki("slow_mem_cycles", memreq_cnt, 5);
        tick(); tick();

        // Timeout with a memory that never answers, then a normal transfer.
        clear_obs();
        force_lat = 1000;
        r1_req = 1'b1; r1_addr = 8'h44;
        serve(1, 1'b0, 40);
        if (done_who.size() >= 1) begin
            chki("tmo_who", done_who[0], 1);
            chk1("tmo_err", done_err[0], 1'b1);
            chkv("tmo_data", done_data[0], '0);
        end
        chki("tmo_mem_cycles", memreq_cnt, TMO);
        tick();
        clear_obs();
        force_lat = 0;
        r0_req = 1'b1; r0_addr = 8'h05;
        serve(1, 1'b0, 20);
        if (done_who.size() >= 1) begin
            chki("post_tmo_who", done_who[0], 0);
            chk1("post_tmo_err", done_err[0], 1'b0);
            chkv("post_tmo_data", done_data[0], LIT05);
        end
        tick(); tick();

        // Reset on the second ACCESS cycle, request left pending.
        clear_obs();
        force_lat = 1000;
        r0_req = 1'b1; r0_addr = 8'h05;
        left = 10;
        while (mem_req !== 1'b1 && left > 0) begin
            tick();
            left--;
        end
        chk1("rstmid_access_seen", mem_req, 1'b1);
        tick();
        reset_n = 1'b0;
        tick();
        chk1("rstmid_mem_req", mem_req, 1'b0);
        chk1("rstmid_busy", busy, 1'b0);
        reset_n = 1'b1;
        force_lat = 0;
        tick();
        chki("rstmid_no_done", done_who.size(), 0);
        serve(1, 1'b0, 20);
        if (done_who.size() >= 1) begin
            chki("rstmid_regrant_who", done_who[0], 0);
            chk1("rstmid_regrant_err", done_err[0], 1'b0);
        end
        tick(); tick();

        // Randomized traffic with idle-handshake noise, random latency and occasional resets.
        force_lat = -1;
        noise_en  = 1'b1;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            d0 = r0_done;
            d1 = r1_done;
            tick();
            reset_n = ($urandom_range(0, 399) != 0);
            if (r0_req && d0) begin
                if ($urandom_range(0, 1) == 1) r0_addr = AW'($urandom_range(0, 255));
                else r0_req = 1'b0;
            end else if (!r0_req && $urandom_range(0, 3) == 0) begin
                r0_req = 1'b1; r0_addr = AW'($urandom_range(0, 255));
            end else if (r0_req && $urandom_range(0, 199) == 0) begin
                r0_req = 1'b0;
            end
            if (r1_req && d1) begin
                if ($urandom_range(0, 1) == 1) r1_addr = AW'($urandom_range(0, 255));
                else r1_req = 1'b0;
            end else if (!r1_req && $urandom_range(0, 3) == 0) begin
                r1_req = 1'b1; r1_addr = AW'($urandom_range(0, 255));
            end else if (r1_req && $urandom_range(0, 199) == 0) begin
                r1_req = 1'b0;
            end
        end
        reset_n = 1'b1;
        r0_req  = 1'b0;
        r1_req  = 1'b0;
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got no end of test want finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
